// File: rtl/sram_axi_bridge.sv
// rtl/sram_axi_bridge.sv - sram-like inst/data cache ports to single-outstanding AXI master bridge
module sram_axi_bridge (
    input  logic        clk,
    input  logic        rst,

    input  logic        cache_inst_req,
    input  logic        cache_inst_wr,
    input  logic [1:0]  cache_inst_size,
    input  logic [31:0] cache_inst_addr,
    input  logic [31:0] cache_inst_wdata,
    output logic [31:0] cache_inst_rdata,
    output logic        cache_inst_addr_ok,
    output logic        cache_inst_data_ok,

    input  logic        cache_data_req,
    input  logic        cache_data_wr,
    input  logic [1:0]  cache_data_size,
    input  logic [31:0] cache_data_addr,
    input  logic [31:0] cache_data_wdata,
    output logic [31:0] cache_data_rdata,
    output logic        cache_data_addr_ok,
    output logic        cache_data_data_ok,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_WR_REQ,
        S_WR_RESP,
        S_DONE
    } state_t;

    state_t      r_state;
    logic        r_src;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_inst_rdata;
    logic [31:0] r_data_rdata;
    logic        r_aw_pend;
    logic        r_w_pend;

    logic        w_grant_data;
    logic        w_grant_inst;
    logic        w_req_wr;
    logic [1:0]  w_req_size;
    logic [31:0] w_req_addr;
    logic [31:0] w_req_wdata;
    logic        w_aw_done;
    logic        w_w_done;
    logic [3:0]  w_wstrb;
    logic        w_unused;

    // Data cache has fixed priority over instruction fetch.
    assign w_grant_data = (r_state == S_IDLE) && cache_data_req;
    assign w_grant_inst = (r_state == S_IDLE) && !cache_data_req && cache_inst_req;

    assign w_req_wr    = cache_data_req ? cache_data_wr    : cache_inst_wr;
    assign w_req_size  = cache_data_req ? cache_data_size  : cache_inst_size;
    assign w_req_addr  = cache_data_req ? cache_data_addr  : cache_inst_addr;
    assign w_req_wdata = cache_data_req ? cache_data_wdata : cache_inst_wdata;

    assign w_aw_done = !r_aw_pend || awready;
    assign w_w_done  = !r_w_pend  || wready;
    assign w_unused  = ^rid;

    always_comb begin
        w_wstrb = 4'b1111;
        case (r_size)
            2'd0:    w_wstrb = 4'b0001 << r_addr[1:0];
            2'd1:    w_wstrb = 4'b0011 << {r_addr[1], 1'b0};
            default: w_wstrb = 4'b1111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_src        <= 1'b0;
            r_size       <= 2'd0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_inst_rdata <= 32'd0;
            r_data_rdata <= 32'd0;
            r_aw_pend    <= 1'b0;
            r_w_pend     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_data || w_grant_inst) begin
                        r_src   <= w_grant_data;
                        r_size  <= w_req_size;
                        r_addr  <= w_req_addr;
                        r_wdata <= w_req_wdata;
                        if (w_req_wr) begin
                            r_state   <= S_WR_REQ;
                            r_aw_pend <= 1'b1;
                            r_w_pend  <= 1'b1;
                        end else begin
                            r_state <= S_RD_ADDR;
                        end
                    end
                end
                S_RD_ADDR: begin
                    if (arready)
                        r_state <= S_RD_DATA;
                end
                S_RD_DATA: begin
                    if (rvalid) begin
                        if (r_src)
                            r_data_rdata <= rdata;
                        else
                            r_inst_rdata <= rdata;
                        r_state <= S_DONE;
                    end
                end
                S_WR_REQ: begin
                    // AW and W complete independently, in either order.
                    if (awready)
                        r_aw_pend <= 1'b0;
                    if (wready)
                        r_w_pend <= 1'b0;
                    if (w_aw_done && w_w_done)
                        r_state <= S_WR_RESP;
                end
                S_WR_RESP: begin
                    if (bvalid)
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cache_data_addr_ok = w_grant_data;
    assign cache_inst_addr_ok = w_grant_inst;
    assign cache_data_data_ok = (r_state == S_DONE) && r_src;
    assign cache_inst_data_ok = (r_state == S_DONE) && !r_src;
    assign cache_data_rdata   = r_data_rdata;
    assign cache_inst_rdata   = r_inst_rdata;

    assign arid    = {3'b000, r_src};
    assign araddr  = r_addr;
    assign arsize  = {1'b0, r_size};
    assign arvalid = (r_state == S_RD_ADDR);
    assign rready  = (r_state == S_RD_DATA);

    assign awid    = 4'd1;
    assign awaddr  = r_addr;
    assign awsize  = {1'b0, r_size};
    assign awvalid = r_aw_pend;
    assign wdata   = r_wdata;
    assign wstrb   = w_wstrb;
    assign wvalid  = r_w_pend;
    assign bready  = (r_state == S_WR_RESP);

endmodule
